// File: rtl/seq_pkg.sv
// seq_pkg: shared types and default widths for the sample sequencer.
// state_e doubles as the stage code reported on err_stage.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, FILT, PEAK, DAC} state_e;
    localparam int SEQ_DATA_W      = 10;
    localparam int SEQ_OVR_W       = 8;
    localparam int SEQ_TIMEOUT_CYC = 1024;
endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: per-stage cycle counter; restarts on stage entry, pulses expire_o on the last allowed cycle.
// Ports: clk, reset_n (async, active-low), enter_i (a new stage starts next cycle),
//        active_i (a stage is running), expire_o (stage has used TIMEOUT_CYC cycles).
module seq_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enter_i,
    input  logic active_i,
    output logic expire_o
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d    = (enter_i || !active_i) ? '0 : cnt_q + CW'(1);
    assign expire_o = active_i && cnt_q == CW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: steps each ADC sample through filter, peak finder and DAC with start/done handshakes.
// Ports: clk, reset_n (async, active-low); sample_valid/sample_data in; filt/peak/dac start out, done in;
//        filt_sample (captured sample), busy, frame_done, overrun_cnt (saturating drop count),
//        err_timeout/err_stage (watchdog, only with SEQ_TIMEOUT_EN defined; tied to 0 otherwise).
module sample_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W      = SEQ_DATA_W,
    parameter int TIMEOUT_CYC = SEQ_TIMEOUT_CYC,
    parameter int OVR_W       = SEQ_OVR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              filt_start,
    output logic [DATA_W-1:0] filt_sample,
    input  logic              filt_done,
    output logic              peak_start,
    input  logic              peak_done,
    output logic              dac_start,
    input  logic              dac_done,
    output logic              busy,
    output logic              frame_done,
    output logic [OVR_W-1:0]  overrun_cnt,
    output logic              err_timeout,
    output logic [1:0]        err_stage
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] samp_q, samp_d, pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [OVR_W-1:0]  ovr_q, ovr_d;
    logic              filt_start_q, filt_start_d, peak_start_q, peak_start_d;
    logic              dac_start_q, dac_start_d, frame_done_q, frame_done_d;
    logic              first, done, dac_fin, expire;

    // The start pulse marks a stage's first cycle, where done is not yet trusted.
    assign first   = filt_start_q | peak_start_q | dac_start_q;
    assign done    = !first && ((state_q == FILT && filt_done) || (state_q == PEAK && peak_done) ||
                                (state_q == DAC && dac_done));
    assign dac_fin = state_q == DAC && done;

`ifdef SEQ_TIMEOUT_EN
    logic   wd_expire, err_q;
    state_e err_stage_q;
    seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk      (clk),
        .reset_n  (reset_n),
        .enter_i  (state_d != state_q),
        .active_i (state_q != IDLE),
        .expire_o (wd_expire)
    );
    // A done arriving on the last allowed cycle still wins over the timeout.
    assign expire = wd_expire && !done;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            err_q       <= 1'b0;
            err_stage_q <= IDLE;
        end else if (expire) begin
            err_q       <= 1'b1;
            err_stage_q <= state_q;
        end
    assign err_timeout = err_q;
    assign err_stage   = err_stage_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
    assign expire         = 1'b0;
    assign err_timeout    = 1'b0;
    assign err_stage      = 2'b00;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (expire)                 state_d = IDLE;
        else if (state_q == IDLE)   state_d = sample_valid ? FILT : IDLE;
        else if (done)              state_d = state_q == FILT ? PEAK :
                                              state_q == PEAK ? DAC  :
                                              (pend_vld_q || sample_valid) ? FILT : IDLE;
    end

    always_comb begin
        samp_d     = samp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovr_d      = ovr_q;
        if (state_q == IDLE && sample_valid) begin
            samp_d = sample_data;
        end else if (dac_fin && pend_vld_q) begin
            // Oldest sample starts the next frame; a simultaneous arrival takes its slot.
            samp_d     = pend_q;
            pend_d     = sample_data;
            pend_vld_d = sample_valid;
        end else if (dac_fin && sample_valid) begin
            samp_d = sample_data;
        end else if (state_q != IDLE && sample_valid) begin
            if (!pend_vld_q) begin
                pend_d     = sample_data;
                pend_vld_d = 1'b1;
            end else if (~&ovr_q) begin
                ovr_d = ovr_q + OVR_W'(1);
            end
        end
        if (expire) pend_vld_d = 1'b0;
        filt_start_d = state_d == FILT && state_d != state_q;
        peak_start_d = state_d == PEAK && state_d != state_q;
        dac_start_d  = state_d == DAC  && state_d != state_q;
        frame_done_d = dac_fin;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            samp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            ovr_q        <= '0;
            filt_start_q <= 1'b0;
            peak_start_q <= 1'b0;
            dac_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            samp_q       <= samp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            ovr_q        <= ovr_d;
            filt_start_q <= filt_start_d;
            peak_start_q <= peak_start_d;
            dac_start_q  <= dac_start_d;
            frame_done_q <= frame_done_d;
        end

    assign filt_start  = filt_start_q;
    assign peak_start  = peak_start_q;
    assign dac_start   = dac_start_q;
    assign frame_done  = frame_done_q;
    assign filt_sample = samp_q;
    assign overrun_cnt = ovr_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: directed stimulus against a queue-based behavioural model of the sequencer.
module tb_sample_sequencer;
    localparam int DW   = 10;
    localparam int OW   = 8;
    localparam int TO   = 1024;
    localparam int OMAX = (1 << OW) - 1;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          sample_valid = 1'b0, filt_done = 1'b0, peak_done = 1'b0, dac_done = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          filt_start, peak_start, dac_start, busy, frame_done, err_timeout;
    logic [DW-1:0] filt_sample;
    logic [OW-1:0] overrun_cnt;
    logic [1:0]    err_stage;

    int checks = 0, fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sample_sequencer #(.DATA_W(DW), .TIMEOUT_CYC(TO), .OVR_W(OW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .filt_start   (filt_start),
        .filt_sample  (filt_sample),
        .filt_done    (filt_done),
        .peak_start   (peak_start),
        .peak_done    (peak_done),
        .dac_start    (dac_start),
        .dac_done     (dac_done),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun_cnt  (overrun_cnt),
        .err_timeout  (err_timeout),
        .err_stage    (err_stage)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: stage 0 idle, 1 filter, 2 peak, 3 dac; age = cycles spent in the stage.
    // Arrivals while busy join a queue; a finished frame takes the oldest, and the
    // queue is then trimmed to one entry by dropping the newest arrivals.
    int m_stage = 0, m_age = 0, m_cur = 0, m_ovr = 0, m_err = 0, m_err_stage = 0;
    int m_pend[$];
    bit m_fd = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_stage = 0; m_age = 0; m_cur = 0; m_ovr = 0; m_err = 0; m_err_stage = 0; m_fd = 0;
            m_pend.delete();
        end else begin : step
            bit dn;
            dn = m_stage != 0 && m_age > 0 &&
                 ((m_stage == 1 && filt_done) || (m_stage == 2 && peak_done) || (m_stage == 3 && dac_done));
            m_fd = 0;
            if (m_stage == 0) begin
                if (sample_valid) begin
                    m_cur = int'(sample_data);
                    m_stage = 1;
                    m_age = 0;
                end
            end else begin
                if (sample_valid) m_pend.push_back(int'(sample_data));
                if (dn) begin
                    m_age = 0;
                    if (m_stage < 3) m_stage++;
                    else begin
                        m_fd = 1;
                        if (m_pend.size() > 0) begin
                            m_cur = m_pend.pop_front();
                            m_stage = 1;
                        end else m_stage = 0;
                    end
                end
                while (m_pend.size() > 1) begin
                    void'(m_pend.pop_back());
                    if (m_ovr < OMAX) m_ovr++;
                end
                if (!dn) begin
`ifdef SEQ_TIMEOUT_EN
                    if (m_age == TO - 1) begin
                        m_err = 1;
                        m_err_stage = m_stage;
                        m_stage = 0;
                        m_age = 0;
                        m_pend.delete();
                    end else m_age++;
`else
                    m_age++;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_stage != 0);
            chk("filt_start", filt_start, m_stage == 1 && m_age == 0);
            chk("peak_start", peak_start, m_stage == 2 && m_age == 0);
            chk("dac_start", dac_start, m_stage == 3 && m_age == 0);
            chk("filt_sample", filt_sample, m_cur);
            chk("overrun_cnt", overrun_cnt, m_ovr);
            chk("frame_done", frame_done, m_fd);
            chk("err_timeout", err_timeout, m_err);
            chk("err_stage", err_stage, m_err_stage);
        end
    end

    // Done responder: each stage answers lat cycles after its start pulse (-1 = never).
    int lat_f = 2, lat_p = 2, lat_d = 2, cf = -1, cp = -1, cd = -1;

    task automatic tick();
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        cf = filt_start ? lat_f : (cf >= 0 ? cf - 1 : -1);
        cp = peak_start ? lat_p : (cp >= 0 ? cp - 1 : -1);
        cd = dac_start  ? lat_d : (cd >= 0 ? cd - 1 : -1);
        filt_done = cf == 0;
        peak_done = cp == 0;
        dac_done  = cd == 0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", busy, 0);
    endtask

    task automatic trace(output int ps, output int ds, output int fd);
        ps = -1; ds = -1; fd = -1;
        for (int n = 1; n <= 40 && fd < 0; n++) begin
            tick();
            if (peak_start && ps < 0) ps = n;
            if (dac_start && ds < 0) ds = n;
            if (frame_done) fd = n;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int ps, ds, fd, n;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_filt_sample", filt_sample, 0);
        chk("rst_overrun", overrun_cnt, 0);
        chk("rst_err", {err_timeout, err_stage}, 0);
        reset_n = 1'b1;
        tick();

        // Single frame, dones 2 cycles after each start.
        send(10'h155);
        chk("sf_filt_sample", filt_sample, 10'h155);
        chk("sf_filt_start", filt_start, 1);
        trace(ps, ds, fd);
        chk("sf_peak_start_cyc", ps, 3);
        chk("sf_dac_start_cyc", ds, 6);
        chk("sf_frame_done_cyc", fd, 9);
        tick();
        chk("sf_idle", busy, 0);
        chk("sf_frame_done_once", frame_done, 0);
        chk("sf_overrun", overrun_cnt, 0);

        // Queueing: second sample during PEAK re-enters FILT straight from DAC.
        send(10'h123);
        repeat (4) tick();
        send(10'h0AA);
        repeat (4) tick();
        chk("q_filt_start", filt_start, 1);
        chk("q_busy", busy, 1);
        chk("q_filt_sample", filt_sample, 10'h0AA);
        trace(ps, ds, fd);
        chk("q_frame2_done_cyc", fd, 9);
        tick();
        chk("q_idle", busy, 0);

        // Collision: sample in the dac_done cycle with pending empty.
        send(10'h0F0);
        repeat (8) tick();
        send(10'h30F);
        chk("c_filt_start", filt_start, 1);
        chk("c_busy", busy, 1);
        chk("c_filt_sample", filt_sample, 10'h30F);
        chk("c_overrun", overrun_cnt, 0);
        wait_idle(40);

        // Early done: peak_done only in the start cycle is ignored.
        lat_p = 0;
        send(10'h011);
        repeat (4) tick();
        chk("e_stay_dac_start", dac_start, 0);
        chk("e_stay_busy", busy, 1);
        peak_done = 1'b1;
        tick();
        chk("e_adv_dac_start", dac_start, 1);
        lat_p = 2;
        wait_idle(40);

        // Overrun: three samples during FILT keep the first, drop two.
        lat_f = 10;
        send(10'h001);
        send(10'h002);
        send(10'h003);
        send(10'h004);
        chk("o_overrun2", overrun_cnt, 2);
        chk("o_cur_kept", filt_sample, 10'h001);
        lat_f = 2;
        n = 0;
        do begin
            tick();
            n++;
        end while (!filt_start && n < 60);
        chk("o_next_start", filt_start, 1);
        chk("o_pending_first", filt_sample, 10'h002);
        for (int i = 0; i < 300; i++) send(DW'(i));
        chk("o_saturated", overrun_cnt, 8'hFF);
        wait_idle(100);

        // Reset mid-PEAK, then a stray peak_done must have no effect.
        send(10'h2A5);
        repeat (4) tick();
        chk("r_in_peak", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_filt_sample", filt_sample, 0);
        chk("r_overrun", overrun_cnt, 0);
        chk("r_starts", {filt_start, peak_start, dac_start, frame_done}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("r_no_dac_start", dac_start, 0);
        chk("r_still_idle", busy, 0);
        repeat (3) tick();

`ifdef SEQ_TIMEOUT_EN
        // Withheld dac_done: DAC lasts TO cycles, then IDLE with a sticky error.
        lat_d = -1;
        send(10'h3C3);
        n = 0;
        while (busy && n < TO + 100) begin
            tick();
            n++;
        end
        chk("t_cycles", n, TO + 6);
        chk("t_err", err_timeout, 1);
        chk("t_stage", err_stage, 3);
        chk("t_idle", busy, 0);
        lat_d = 2;
        repeat (3) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
